// File: rtl/dm_responder_pkg.sv
// Shared encodings for the data-memory responder: request codes and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dm_responder_pkg;

  // Store width code carried on req_we.
  typedef enum logic [1:0] {
    WE_NONE = 2'b00,
    WE_SW   = 2'b01,
    WE_SH   = 2'b10,
    WE_SB   = 2'b11
  } we_e;

  // Load width/extension code carried on req_re; 110/111 are illegal.
  typedef enum logic [2:0] {
    RE_NONE = 3'b000,
    RE_LW   = 3'b001,
    RE_LH   = 3'b010,
    RE_LHU  = 3'b011,
    RE_LB   = 3'b100,
    RE_LBU  = 3'b101,
    RE_ILL6 = 3'b110,
    RE_ILL7 = 3'b111
  } re_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // Wait-state counter width; covers WAIT_CYC up to 15.
  localparam int CNT_W = 4;

  // A request carrying neither a load nor a store is never accepted.
  function automatic logic is_noop(input logic [1:0] we, input logic [2:0] re);
    return (we == 2'b00) && (re == 3'b000);
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// MEM-stage <-> data-memory responder bus: request handshake, response pulse, stall.
// Latency: n/a (wiring only).
// Backpressure: req_ready low holds the requester; the responder never waits on the response.
// Ports (signals): req_valid/req_ready handshake, req_addr, req_wdata, req_we, req_re,
//                  rsp_valid, rsp_rdata, rsp_err, stall.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_we;
  logic [2:0]  req_re;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        stall;

  modport master (
    output req_valid, req_addr, req_wdata, req_we, req_re,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_we, req_re,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
  );
endinterface

// File: rtl/dm_lane_unit.sv
// Byte-lane logic: store byte-enable/merge, load extract/extend, access error detection.
// Latency: combinational.
// Backpressure: none.
// Ports: i_we/i_re request codes, i_addr_lo byte offset, i_wdata store data,
//        i_rword current array word; o_wword merged word, o_wen write enable,
//        o_rdata extended load data (0 on error/store), o_err access error.
module dm_lane_unit
  import dm_responder_pkg::*;
(
  input  we_e         i_we,
  input  re_e         i_re,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [31:0] o_wword,
  output logic        o_wen,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  logic [3:0]  w_be;
  logic [31:0] w_wlanes;
  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
  assign w_byte = 8'(i_rword >> {i_addr_lo, 3'b000});

  always_comb begin
    w_be     = 4'b0000;
    w_wlanes = 32'h0;
    case (i_we)
      WE_SW: begin
        w_be     = 4'b1111;
        w_wlanes = i_wdata;
      end
      WE_SH: begin
        w_be     = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_wlanes = {2{i_wdata[15:0]}};
      end
      WE_SB: begin
        w_be     = 4'b0001 << i_addr_lo;
        w_wlanes = {4{i_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_err = 1'b0;
    if ((i_we != WE_NONE) && (i_re != RE_NONE))               o_err = 1'b1;
    if ((i_re == RE_ILL6) || (i_re == RE_ILL7))               o_err = 1'b1;
    if (((i_we == WE_SW) || (i_re == RE_LW)) && (i_addr_lo != 2'b00)) o_err = 1'b1;
    if (((i_we == WE_SH) || (i_re == RE_LH) || (i_re == RE_LHU)) && i_addr_lo[0])
      o_err = 1'b1;
  end

  // Unselected lanes keep the current array contents.
  always_comb begin
    o_wword = i_rword;
    for (int k = 0; k < 4; k++) begin
      if (w_be[k]) o_wword[8*k +: 8] = w_wlanes[8*k +: 8];
    end
  end

  assign o_wen = (i_we != WE_NONE) && !o_err;

  always_comb begin
    o_rdata = 32'h0;
    if (!o_err) begin
      case (i_re)
        RE_LW:   o_rdata = i_rword;
        RE_LH:   o_rdata = {{16{w_half[15]}}, w_half};
        RE_LHU:  o_rdata = {16'h0, w_half};
        RE_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
        RE_LBU:  o_rdata = {24'h0, w_byte};
        default: o_rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder for the MEM stage: one byte/half/word access at a time.
// Latency: accept edge T -> rsp_valid in the cycle after edge T+WAIT_CYC+1, for every request kind.
// Backpressure: req_ready only in IDLE; stall freezes the pipeline from request until RESP.
// Ports: clk, rst (sync, active-high); bus (dm_responder_if.slave) carrying the request
//        handshake, single-cycle response pulse with data/error, and stall.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic           clk,
  input  logic           rst,
  dm_responder_if.slave  bus
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_tail;
  logic [ADDR_W-1:0]   r_widx;
  logic [1:0]          r_alo;
  logic [31:0]         r_wdata;
  we_e                 r_we;
  re_e                 r_re;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [0:(1<<ADDR_W)-1];

  logic                w_req_live;
  logic                w_accept;
  logic                w_fire;
  logic                w_ready;
  logic                w_stall;
  logic                w_rsp_vld;
  logic [31:0]         w_rword;
  logic [31:0]         w_wword;
  logic                w_wen;
  logic [31:0]         w_lane_rdata;
  logic                w_lane_err;

  assign w_req_live = bus.req_valid && !is_noop(bus.req_we, bus.req_re);
  assign w_rword    = r_mem[r_widx];

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Outputs are gated with rst so the bus is quiet for the whole reset cycle,
  // including a cycle in which the state register still holds ACCESS/RESP.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fire      = 1'b0;
    w_ready     = 1'b0;
    w_stall     = 1'b0;
    w_rsp_vld   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ready  = !rst;
        w_stall  = !rst && w_req_live;
        w_accept = !rst && w_req_live;
        if (w_req_live) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_stall = !rst;
        // Countdown of WAIT_CYC cycles, then one array cycle: WAIT_CYC+1 edges to RESP.
        if ((r_cnt == '0) && r_tail) begin
          w_fire      = !rst;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_rsp_vld   = !rst;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_tail  <= 1'b0;
      r_widx  <= '0;
      r_alo   <= 2'b00;
      r_wdata <= 32'h0;
      r_we    <= WE_NONE;
      r_re    <= RE_NONE;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_W'(WAIT_CYC - 1);
        r_tail  <= 1'b0;
        r_widx  <= bus.req_addr[ADDR_W+1:2];
        r_alo   <= bus.req_addr[1:0];
        r_wdata <= bus.req_wdata;
        r_we    <= we_e'(bus.req_we);
        r_re    <= re_e'(bus.req_re);
      end else if (r_state == ST_ACCESS) begin
        if (r_cnt != '0) r_cnt  <= r_cnt - CNT_W'(1);
        else             r_tail <= 1'b1;
      end
      // Response data is held until the next access completes.
      if (w_fire) begin
        r_rdata <= w_lane_rdata;
        r_err   <= w_lane_err;
      end
    end
  end

  // Array has no reset; a reset mid-ACCESS suppresses w_fire so nothing is written.
  always_ff @(posedge clk) begin
    if (w_fire && w_wen) r_mem[r_widx] <= w_wword;
  end

  dm_lane_unit u_lane (
    .i_we      (r_we),
    .i_re      (r_re),
    .i_addr_lo (r_alo),
    .i_wdata   (r_wdata),
    .i_rword   (w_rword),
    .o_wword   (w_wword),
    .o_wen     (w_wen),
    .o_rdata   (w_lane_rdata),
    .o_err     (w_lane_err)
  );

  assign bus.req_ready = w_ready;
  assign bus.stall     = w_stall;
  assign bus.rsp_valid = w_rsp_vld;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed requests, queued expectations, independent response monitor.
// Latency: checks WAIT_CYC+1 edges from accept to rsp_valid.
// Backpressure: checks req_ready/stall through ACCESS and RESP.
module tb_dm_responder;

  localparam int WAIT_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_responder_if bus();

  dm_responder #(.ADDR_W(10), .WAIT_CYC(WAIT_CYC)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          t_acc;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  // Response monitor: every rsp_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst === 1'b0 && bus.rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp got rsp_valid=1 exp none (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_rdata"},   bus.rsp_rdata, e.rdata);
        check({e.name, "_err"},     {31'h0, bus.rsp_err}, {31'h0, e.err});
        check({e.name, "_latency"}, cyc - e.t_acc, WAIT_CYC + 1);
      end
    end
  end

  // Issue one request from a negedge, follow it through ACCESS into RESP.
  // Returns in the RESP cycle; keep=1 leaves req_valid high for back-to-back.
  task automatic do_req(input string name, input logic [1:0] we, input logic [2:0] re,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input bit keep, output int waits);
    exp_t e;
    bus.req_we    = we;
    bus.req_re    = re;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    #1;
    waits = 0;
    while (bus.req_ready !== 1'b1 && waits < 20) begin
      @(negedge clk); #1;
      waits++;
    end
    if (waits >= 20) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout got req_ready=%b exp 1", name, bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    check({name, "_stall_idle"}, {31'h0, bus.stall}, 32'h1);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.t_acc = cyc + 1;
    e.name  = name;
    sb_q.push_back(e);
    @(posedge clk);
    for (int i = 0; i < WAIT_CYC + 1; i++) begin
      @(negedge clk); #1;
      check({name, "_ready_access"}, {31'h0, bus.req_ready}, 32'h0);
      check({name, "_stall_access"}, {31'h0, bus.stall},     32'h1);
    end
    @(negedge clk); #1;
    check({name, "_stall_resp"}, {31'h0, bus.stall},     32'h0);
    check({name, "_ready_resp"}, {31'h0, bus.req_ready}, 32'h0);
    if (!keep) bus.req_valid = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got timeout exp $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int n;
    bus.req_valid = 1'b0;
    bus.req_we    = 2'b00;
    bus.req_re    = 3'b000;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // Request pending during reset must not raise stall or ready.
    bus.req_valid = 1'b1;
    bus.req_we    = 2'b01;
    #1;
    check("rst_ready",     {31'h0, bus.req_ready}, 32'h0);
    check("rst_stall",     {31'h0, bus.stall},     32'h0);
    check("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("rst_rdata",     bus.rsp_rdata,          32'h0);
    check("rst_err",       {31'h0, bus.rsp_err},   32'h0);
    bus.req_valid = 1'b0;
    bus.req_we    = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check("post_rst_stall", {31'h0, bus.stall},     32'h0);

    // No-op request: ignored, no stall, stays ready.
    bus.req_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("noop_ready", {31'h0, bus.req_ready}, 32'h1);
      check("noop_stall", {31'h0, bus.stall},     32'h0);
      @(negedge clk); #1;
    end
    bus.req_valid = 1'b0;

    // Test 1
    do_req("sw10",   2'b01, 3'b000, 32'h10, 32'h12345678, 32'h0,        1'b0, 0, w);
    do_req("lw10_a", 2'b00, 3'b001, 32'h10, 32'h0,        32'h12345678, 1'b0, 0, w);
    // Test 2
    do_req("sb11",   2'b11, 3'b000, 32'h11, 32'hFFFFFFAB, 32'h0,        1'b0, 0, w);
    do_req("lw10_b", 2'b00, 3'b001, 32'h10, 32'h0,        32'h1234AB78, 1'b0, 0, w);
    do_req("lb11",   2'b00, 3'b100, 32'h11, 32'h0,        32'hFFFFFFAB, 1'b0, 0, w);
    do_req("lbu11",  2'b00, 3'b101, 32'h11, 32'h0,        32'h000000AB, 1'b0, 0, w);
    // Test 3
    do_req("sh12",   2'b10, 3'b000, 32'h12, 32'h00008001, 32'h0,        1'b0, 0, w);
    do_req("lh12",   2'b00, 3'b010, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 0, w);
    do_req("lhu12",  2'b00, 3'b011, 32'h12, 32'h0,        32'h00008001, 1'b0, 0, w);
    do_req("lw10_c", 2'b00, 3'b001, 32'h10, 32'h0,        32'h8001AB78, 1'b0, 0, w);
    do_req("lb10",   2'b00, 3'b100, 32'h10, 32'h0,        32'h00000078, 1'b0, 0, w);
    do_req("lh10",   2'b00, 3'b010, 32'h10, 32'h0,        32'hFFFFAB78, 1'b0, 0, w);
    // Test 4: errors leave memory untouched and return zero data.
    do_req("lw13_err", 2'b00, 3'b001, 32'h13, 32'h0,      32'h0,        1'b1, 0, w);
    do_req("sh11_err", 2'b10, 3'b000, 32'h11, 32'h0000FFFF, 32'h0,      1'b1, 0, w);
    do_req("ill6_err", 2'b00, 3'b110, 32'h10, 32'h0,      32'h0,        1'b1, 0, w);
    do_req("both_err", 2'b01, 3'b001, 32'h10, 32'hDEADBEEF, 32'h0,      1'b1, 0, w);
    do_req("lw10_d",   2'b00, 3'b001, 32'h10, 32'h0,      32'h8001AB78, 1'b0, 0, w);
    // Test 5: back-to-back with req_valid held high.
    do_req("b2b_lw",   2'b00, 3'b001, 32'h10, 32'h0,      32'h8001AB78, 1'b0, 1, w);
    do_req("b2b_lbu",  2'b00, 3'b101, 32'h13, 32'h0,      32'h00000080, 1'b0, 0, w);
    check("b2b_gap", w, 1);

    // Test 6: reset during ACCESS aborts the store.
    do_req("pre20", 2'b01, 3'b000, 32'h20, 32'h0, 32'h0, 1'b0, 0, w);
    bus.req_we    = 2'b01;
    bus.req_re    = 3'b000;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'hFFFFFFFF;
    bus.req_valid = 1'b1;
    #1;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("abort_accept_wait", n, 1);
    @(posedge clk);
    @(negedge clk); #1;
    check("abort_stall_access", {31'h0, bus.stall}, 32'h1);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    check("abort_rst_ready",     {31'h0, bus.req_ready}, 32'h0);
    check("abort_rst_stall",     {31'h0, bus.stall},     32'h0);
    check("abort_rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("abort_rst_rdata",     bus.rsp_rdata,          32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("abort_idle_ready", {31'h0, bus.req_ready}, 32'h1);
    do_req("lw20", 2'b00, 3'b001, 32'h20, 32'h0, 32'h0, 1'b0, 0, w);

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("sb_drain", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
